// File: rtl/note_pair_writer.sv
// Producer side of the scoring FIFO: averages sung pitch per note window and pairs it with the
// song-ROM reference frequency. Optional build macro: PITCH_RANGE_FILTER_EN (range-gates samples).
module note_pair_writer #(
    parameter int NUM_NOTES = 32,
    parameter int ADDR_W    = 5,
    parameter int AVG_SHIFT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              go,
    input  logic              sample_valid,
    input  logic [14:0]       sung_freq_in,
    input  logic              note_tick,
    output logic [ADDR_W-1:0] ref_addr,
    input  logic [14:0]       ref_data,
    input  logic              fifo_full,
    output logic              wr_en,
    output logic [14:0]       sung_freq_out,
    output logic [14:0]       ref_freq_out,
    output logic              start,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int ACC_W = 15 + AVG_SHIFT;
    localparam int CNT_W = AVG_SHIFT + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(1 << AVG_SHIFT);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NOTES - 1);
    localparam logic [14:0]       SENTINEL = 15'h7FFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_FETCH,
        S_WRITE,
        S_START,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] ref_addr_q, ref_addr_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [14:0]       sung_q, sung_d;
    logic [14:0]       ref_q, ref_d;
    logic              ovr_q, ovr_d;

    logic              sample_ok;
    logic              take;
    logic [ACC_W-1:0]  acc_nx;
    logic [CNT_W-1:0]  cnt_nx;

`ifdef PITCH_RANGE_FILTER_EN
    assign sample_ok = sample_valid && (sung_freq_in >= 15'd16) && (sung_freq_in <= 15'd8000);
`else
    assign sample_ok = sample_valid;
`endif

    // Window saturates at 2^AVG_SHIFT samples; later samples in the same window are dropped.
    assign take   = sample_ok && (cnt_q < FULL_CNT);
    assign acc_nx = take ? acc_q + ACC_W'(sung_freq_in) : acc_q;
    assign cnt_nx = take ? cnt_q + CNT_W'(1) : cnt_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ref_addr_d = ref_addr_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sung_d     = sung_q;
        ref_d      = ref_q;
        ovr_d      = ovr_q;
        wr_en      = 1'b0;
        start      = 1'b0;

        // Strobes are gated by enable too, so a stalled WRITE/START never repeats a pulse.
        if (enable) begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        state_d    = S_COLLECT;
                        idx_d      = '0;
                        ref_addr_d = '0;
                        acc_d      = '0;
                        cnt_d      = '0;
                        ovr_d      = 1'b0;
                    end
                end
                S_COLLECT: begin
                    acc_d = acc_nx;
                    cnt_d = cnt_nx;
                    if (note_tick) begin
                        sung_d     = (cnt_nx == FULL_CNT) ? acc_nx[AVG_SHIFT +: 15] : SENTINEL;
                        ref_addr_d = idx_q;
                        state_d    = S_FETCH;
                    end
                end
                S_FETCH: begin
                    ref_d   = ref_data;
                    state_d = S_WRITE;
                end
                S_WRITE: begin
                    if (!fifo_full) begin
                        wr_en   = 1'b1;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    start = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_COLLECT;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // Set after the go-clear so a tick arriving with go is still flagged.
            if (note_tick && (state_q != S_COLLECT)) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            ref_addr_q <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            sung_q     <= '0;
            ref_q      <= '0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ref_addr_q <= ref_addr_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sung_q     <= sung_d;
            ref_q      <= ref_d;
            ovr_q      <= ovr_d;
        end
    end

    assign ref_addr      = ref_addr_q;
    assign sung_freq_out = sung_q;
    assign ref_freq_out  = ref_q;
    assign overrun       = ovr_q;
    assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_note_pair_writer.sv
// Self-checking bench for note_pair_writer: table vectors, hand-written corner sequences and
// randomized note windows scored against a sample-list averaging model.
module tb_note_pair_writer;

    localparam int NN    = 2;
    localparam int AW    = 5;
    localparam int AS    = 3;
    localparam int AVG_N = 1 << AS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b1;
    logic          go = 1'b0;
    logic          sample_valid = 1'b0;
    logic [14:0]   sung_freq_in = '0;
    logic          note_tick = 1'b0;
    logic          fifo_full = 1'b0;
    logic [AW-1:0] ref_addr;
    logic [14:0]   ref_data;
    logic          wr_en, start, busy, done, overrun;
    logic [14:0]   sung_freq_out, ref_freq_out;

    logic [14:0]   rom [0:31];
    assign ref_data = rom[ref_addr];

    note_pair_writer #(.NUM_NOTES(NN), .ADDR_W(AW), .AVG_SHIFT(AS)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .go(go),
        .sample_valid(sample_valid), .sung_freq_in(sung_freq_in), .note_tick(note_tick),
        .ref_addr(ref_addr), .ref_data(ref_data), .fifo_full(fifo_full), .wr_en(wr_en),
        .sung_freq_out(sung_freq_out), .ref_freq_out(ref_freq_out), .start(start),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int exp_wr = 0;
    int cur_idx = 0;
    bit song_active = 1'b0;
    bit exp_ovr = 1'b0;
    logic [14:0] smp_q [$];

    always @(negedge clk) if (wr_en === 1'b1) wr_cnt <= wr_cnt + 1;

    typedef struct {
        int          na;
        logic [14:0] va;
        int          nb;
        logic [14:0] vb;
        bit          same;
        int          ff;
        logic [14:0] exp;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_range(input logic [14:0] v);
`ifdef PITCH_RANGE_FILTER_EN
        return (v >= 15'd16) && (v <= 15'd8000);
`else
        return 1'b1;
`endif
    endfunction

    // Average of the first AVG_N accepted samples, or the sentinel if the window is short.
    function automatic logic [14:0] model_avg();
        int n = 0;
        int sum = 0;
        foreach (smp_q[i]) begin
            if (in_range(smp_q[i]) && n < AVG_N) begin
                sum += int'(smp_q[i]);
                n++;
            end
        end
        return (n == AVG_N) ? 15'(sum / AVG_N) : 15'h7FFF;
    endfunction

    task automatic start_song();
        go = 1'b1;
        tick();
        go = 1'b0;
        cur_idx = 0;
        song_active = 1'b1;
        exp_ovr = 1'b0;
        chk("go_done", done, 0);
        chk("go_busy", busy, 1);
        chk("go_ref_addr", ref_addr, 0);
        chk("go_overrun", overrun, 0);
    endtask

    // Plays smp_q into a COLLECT window, then walks FETCH/WRITE/START checking each cycle.
    task automatic do_note(input bit same, input int ff, input bit gaps, input bit tick_fetch,
                           input logic [14:0] exp_sung);
        for (int i = 0; i < smp_q.size(); i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                sample_valid = 1'b0;
                note_tick = 1'b0;
                tick();
            end
            sample_valid = 1'b1;
            sung_freq_in = smp_q[i];
            note_tick = same && (i == smp_q.size() - 1);
            tick();
        end
        if (!(same && smp_q.size() > 0)) begin
            sample_valid = 1'b0;
            note_tick = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        note_tick = 1'b0;
        chk("fetch_wr_en", wr_en, 0);
        chk("fetch_busy", busy, 1);
        chk("fetch_ref_addr", ref_addr, cur_idx);
        note_tick = tick_fetch;
        fifo_full = (ff > 0);
        tick();
        note_tick = 1'b0;
        if (tick_fetch) exp_ovr = 1'b1;
        for (int c = 0; c < ff; c++) begin
            fifo_full = 1'b1;
            #1;
            chk("bp_wr_en", wr_en, 0);
            chk("bp_sung_hold", sung_freq_out, exp_sung);
            chk("bp_ref_hold", ref_freq_out, rom[cur_idx]);
            tick();
        end
        fifo_full = 1'b0;
        #1;
        chk("write_wr_en", wr_en, 1);
        chk("write_sung", sung_freq_out, exp_sung);
        chk("write_ref", ref_freq_out, rom[cur_idx]);
        chk("write_start", start, 0);
        chk("write_overrun", overrun, exp_ovr);
        exp_wr++;
        tick();
        chk("start_pulse", start, 1);
        chk("start_wr_en", wr_en, 0);
        tick();
        chk("post_start", start, 0);
        if (cur_idx == NN - 1) begin
            chk("end_done", done, 1);
            chk("end_busy", busy, 0);
            song_active = 1'b0;
        end else begin
            chk("next_busy", busy, 1);
            chk("next_done", done, 0);
            cur_idx++;
        end
    endtask

    task automatic finish_song();
        while (song_active) begin
            smp_q.delete();
            repeat (AVG_N) smp_q.push_back(15'd1000);
            do_note(1'b0, 0, 1'b0, 1'b0, 15'd1000);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 15'(100 + i * 10);
        rom[0] = 15'd440;
        rom[1] = 15'd523;

        tbl[0]  = '{8, 15'd440,  0, 15'd0,   1'b0, 0,  15'd440};
        tbl[1]  = '{4, 15'd400,  4, 15'd403, 1'b1, 0,  15'd401};
        tbl[2]  = '{8, 15'd100,  4, 15'd900, 1'b0, 2,  15'd100};
        tbl[3]  = '{5, 15'd1000, 0, 15'd0,   1'b0, 0,  15'h7FFF};
        tbl[4]  = '{0, 15'd0,    0, 15'd0,   1'b0, 1,  15'h7FFF};
        tbl[5]  = '{7, 15'd500,  1, 15'd700, 1'b1, 0,  15'd525};
        tbl[6]  = '{8, 15'd8000, 0, 15'd0,   1'b0, 0,  15'd8000};
        tbl[7]  = '{8, 15'd16,   0, 15'd0,   1'b1, 0,  15'd16};
        tbl[8]  = '{8, 15'd1234, 0, 15'd0,   1'b0, 10, 15'd1234};
`ifdef PITCH_RANGE_FILTER_EN
        tbl[9]  = '{8, 15'd9000,  0, 15'd0,  1'b0, 0,  15'h7FFF};
        tbl[10] = '{4, 15'd15,    8, 15'd16, 1'b0, 0,  15'd16};
        tbl[11] = '{8, 15'd32767, 0, 15'd0,  1'b0, 0,  15'h7FFF};
`else
        tbl[9]  = '{8, 15'd9000,  0, 15'd0,  1'b0, 0,  15'd9000};
        tbl[10] = '{4, 15'd15,    8, 15'd16, 1'b0, 0,  15'd15};
        tbl[11] = '{8, 15'd32767, 0, 15'd0,  1'b0, 0,  15'd32767};
`endif

        // Reset state
        tick();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_ref_addr", ref_addr, 0);
        chk("rst_sung", sung_freq_out, 0);
        chk("rst_ref", ref_freq_out, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // Table-driven note windows
        foreach (tbl[k]) begin
            if (!song_active) start_song();
            smp_q.delete();
            repeat (tbl[k].na) smp_q.push_back(tbl[k].va);
            repeat (tbl[k].nb) smp_q.push_back(tbl[k].vb);
            do_note(tbl[k].same, tbl[k].ff, 1'b0, 1'b0, tbl[k].exp);
        end
        finish_song();

        // Overrun: tick during FETCH and during DONE, then go clears it
        start_song();
        smp_q.delete();
        repeat (AVG_N) smp_q.push_back(15'd440);
        do_note(1'b0, 0, 1'b0, 1'b1, 15'd440);
        finish_song();
        note_tick = 1'b1;
        tick();
        note_tick = 1'b0;
        chk("done_overrun", overrun, 1);
        chk("done_hold", done, 1);
        chk("ovr_no_extra_write", wr_cnt, exp_wr);
        start_song();
        finish_song();

        // Randomized windows against the averaging model
        for (int n = 0; n < 40; n++) begin
            if (!song_active) begin
                for (int i = 0; i < NN; i++) rom[i] = 15'($urandom_range(1, 32767));
                start_song();
            end
            smp_q.delete();
            repeat ($urandom_range(0, 12)) begin
                if ($urandom_range(0, 3) == 0) smp_q.push_back(15'($urandom_range(0, 32767)));
                else smp_q.push_back(15'($urandom_range(16, 8000)));
            end
            do_note(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1, 1'b0, model_avg());
        end
        finish_song();

        // Reset mid-WRITE abandons the pending write
        start_song();
        for (int i = 0; i < AVG_N; i++) begin
            sample_valid = 1'b1;
            sung_freq_in = 15'd300;
            tick();
        end
        sample_valid = 1'b0;
        note_tick = 1'b1;
        tick();
        note_tick = 1'b0;
        fifo_full = 1'b1;
        tick();
        chk("rw_wr_en_before", wr_en, 0);
        rst_n = 1'b0;
        fifo_full = 1'b0;
        #1;
        chk("rw_wr_en", wr_en, 0);
        chk("rw_start", start, 0);
        chk("rw_busy", busy, 0);
        chk("rw_sung", sung_freq_out, 0);
        chk("rw_ref_addr", ref_addr, 0);
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        chk("rw_idle_busy", busy, 0);
        chk("rw_idle_done", done, 0);
        chk("rw_no_write", wr_cnt, exp_wr);
        song_active = 1'b0;

        // Enable low in COLLECT freezes count and ignores note_tick
        start_song();
        for (int i = 0; i < 3; i++) begin
            sample_valid = 1'b1;
            sung_freq_in = 15'd200;
            tick();
        end
        enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            sample_valid = 1'b1;
            sung_freq_in = 15'd500;
            note_tick = (c == 2);
            tick();
            chk("en_busy", busy, 1);
            chk("en_overrun", overrun, 0);
        end
        note_tick = 1'b0;
        sample_valid = 1'b0;
        enable = 1'b1;
        smp_q.delete();
        repeat (5) smp_q.push_back(15'd600);
        do_note(1'b1, 0, 1'b0, 1'b0, 15'd450);
        finish_song();

        tick();
        chk("total_writes", wr_cnt, exp_wr);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
